spi_mem_responder: RTL and testbench

SPI memory target that answers the CPU's SPI memory controller: it receives READ/WRITE command frames on `sclk`/`mosi`/`cs_n`, stores bytes in an internal byte array and returns read data on `miso`. It stands in for an external SPI RAM behind either chip select. It is used in simulation benches and as optional on-die scratch/boot memory. A backdoor load port preloads program images before the CPU leaves reset.

---
 rtl/spi_mem_responder.sv | 184 ++++++++++++++++++
 tb/tb_spi_mem_responder.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_mem_responder.sv
// SPI mode-0 memory target: READ (0x03) / WRITE (0x02) frames with a 24-bit address
// into a 2^ADDR_BITS byte array, plus a backdoor load port usable while deselected.
module spi_mem_responder #(
  parameter int ADDR_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sclk,
  input  logic                 mosi,
  input  logic                 cs_n,
  output logic                 miso,
  output logic                 busy,
  input  logic                 load_en,
  input  logic [ADDR_BITS-1:0] load_addr,
  input  logic [7:0]           load_data
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, RD, WR, IGN} state_t;

  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_WRITE = 8'h02;

  logic [7:0] mem [2**ADDR_BITS];

  logic [1:0] sclk_sync_q, mosi_sync_q, cs_sync_q;
  logic       sclk_s, mosi_s, cs_s;
  logic       sclk_d, cs_d;
  logic       sclk_rise, sclk_fall, cs_fall;
  logic [1:0] settle;
  logic       armed;

  state_t                 state, state_nxt;
  logic [2:0]             bit_cnt, bit_cnt_nxt;
  logic [1:0]             byte_cnt, byte_cnt_nxt;
  logic [7:0]             shreg, shreg_nxt;
  logic [ADDR_BITS-1:0]   addr, addr_nxt;
  logic                   is_read, is_read_nxt;
  logic                   miso_nxt;
  logic                   wr_pend, wr_pend_nxt;
  logic [7:0]             rx_byte;
  logic [ADDR_BITS-1:0]   addr_full;

  assign sclk_s    = sclk_sync_q[1];
  assign mosi_s    = mosi_sync_q[1];
  assign cs_s      = cs_sync_q[1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign cs_fall   = armed & cs_d & ~cs_s;
  assign busy      = ~cs_s;

  // The synchronizer comes out of reset showing cs_n high, which is not a real
  // observation; only arm the frame start once real pin samples show cs_n high, so a
  // reset taken mid-frame never restarts on the tail of the old frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_sync_q <= 2'b00;
      mosi_sync_q <= 2'b00;
      cs_sync_q   <= 2'b11;
      sclk_d      <= 1'b0;
      cs_d        <= 1'b1;
      settle      <= 2'd0;
      armed       <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples
      // pre-edge values; combinational blocks below use blocking assignments instead.
      sclk_sync_q <= {sclk_sync_q[0], sclk};
      mosi_sync_q <= {mosi_sync_q[0], mosi};
      cs_sync_q   <= {cs_sync_q[0], cs_n};
      sclk_d      <= sclk_s;
      cs_d        <= cs_s;
      if (!settle[1]) settle <= settle + 2'd1;
      if (settle[1] && cs_s) armed <= 1'b1;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves a
    // value unassigned and no latch is inferred.
    state_nxt    = state;
    bit_cnt_nxt  = bit_cnt;
    byte_cnt_nxt = byte_cnt;
    shreg_nxt    = shreg;
    addr_nxt     = addr;
    is_read_nxt  = is_read;
    miso_nxt     = miso;
    wr_pend_nxt  = 1'b0;
    rx_byte      = {shreg[6:0], mosi_s};
    addr_full    = {addr[ADDR_BITS-2:0], mosi_s};

    if (wr_pend) addr_nxt = addr + 1'b1;

    if (cs_s) begin
      state_nxt = IDLE;
      miso_nxt  = 1'b0;
    end else begin
      unique case (state)
        IDLE: if (cs_fall) begin
          state_nxt    = CMD;
          bit_cnt_nxt  = 3'd0;
          byte_cnt_nxt = 2'd0;
          shreg_nxt    = 8'h00;
        end
        CMD: if (sclk_rise) begin
          shreg_nxt   = rx_byte;
          bit_cnt_nxt = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            if (rx_byte == CMD_READ || rx_byte == CMD_WRITE) begin
              state_nxt   = ADDR;
              is_read_nxt = (rx_byte == CMD_READ);
            end else begin
              state_nxt = IGN;
            end
          end
        end
        // The address shifts straight into addr; upper SPI address bits fall off the top.
        ADDR: if (sclk_rise) begin
          addr_nxt    = addr_full;
          bit_cnt_nxt = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            byte_cnt_nxt = byte_cnt + 2'd1;
            if (byte_cnt == 2'd2) begin
              if (is_read) begin
                shreg_nxt = mem[addr_full];
                addr_nxt  = addr_full + 1'b1;
                state_nxt = RD;
              end else begin
                state_nxt = WR;
              end
            end
          end
        end
        RD: if (sclk_fall) begin
          miso_nxt    = shreg[7];
          bit_cnt_nxt = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            shreg_nxt = mem[addr];
            addr_nxt  = addr + 1'b1;
          end else begin
            shreg_nxt = {shreg[6:0], 1'b0};
          end
        end
        WR: if (sclk_rise) begin
          shreg_nxt   = rx_byte;
          bit_cnt_nxt = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) wr_pend_nxt = 1'b1;
        end
        IGN:     miso_nxt  = 1'b0;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      bit_cnt  <= 3'd0;
      byte_cnt <= 2'd0;
      shreg    <= 8'h00;
      addr     <= '0;
      is_read  <= 1'b0;
      miso     <= 1'b0;
      wr_pend  <= 1'b0;
    end else begin
      state    <= state_nxt;
      bit_cnt  <= bit_cnt_nxt;
      byte_cnt <= byte_cnt_nxt;
      shreg    <= shreg_nxt;
      addr     <= addr_nxt;
      is_read  <= is_read_nxt;
      miso     <= miso_nxt;
      wr_pend  <= wr_pend_nxt;
    end
  end

  // NOTE: the array has no reset branch; contents survive rst_n and a reset would
  // prevent mapping onto RAM. A completed SPI byte wins over the backdoor port.
  always_ff @(posedge clk) begin
    if (wr_pend)
      mem[addr] <= shreg;
    else if (load_en && cs_s)
      mem[load_addr] <= load_data;
  end

endmodule

// File: tb/tb_spi_mem_responder.sv
// Randomized bench for spi_mem_responder: a plain byte-array model tracks memory and
// every SPI read byte, miso idle level and busy level is compared against it.
module tb_spi_mem_responder;

  localparam int AB   = 8;
  localparam int HALF = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sclk = 1'b0;
  logic          mosi = 1'b0;
  logic          cs_n = 1'b1;
  logic          load_en = 1'b0;
  logic [AB-1:0] load_addr = '0;
  logic [7:0]    load_data = 8'h00;
  logic          miso;
  logic          busy;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] model_mem [256];

  always #5 clk = ~clk;

  spi_mem_responder #(.ADDR_BITS(AB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sclk      (sclk),
    .mosi      (mosi),
    .cs_n      (cs_n),
    .miso      (miso),
    .busy      (busy),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One mode-0 bit: miso sampled just before the rising edge, as a controller would.
  task automatic spi_bit(input logic b, output logic r);
    mosi = b;
    repeat (HALF) @(negedge clk);
    r = miso;
    sclk = 1'b1;
    repeat (HALF) @(negedge clk);
    sclk = 1'b0;
  endtask

  task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(tx[i], r);
      rx[i] = r;
    end
  endtask

  task automatic frame_begin();
    @(negedge clk);
    cs_n = 1'b0;
    repeat (6) @(negedge clk);
    check("busy_in_frame", {31'd0, busy}, 32'd1);
  endtask

  task automatic frame_end();
    repeat (HALF) @(negedge clk);
    cs_n = 1'b1;
    repeat (8) @(negedge clk);
    check("busy_after_frame", {31'd0, busy}, 32'd0);
  endtask

  task automatic send_hdr(input logic [7:0] cmd, input logic [23:0] a);
    logic [7:0] rx;
    xfer(cmd, rx);
    check("hdr_miso_low", {24'd0, rx}, 32'd0);
    for (int i = 2; i >= 0; i--) begin
      xfer(a[8*i +: 8], rx);
      check("hdr_miso_low", {24'd0, rx}, 32'd0);
    end
  endtask

  task automatic spi_write(input logic [23:0] a, input logic [31:0] w, input int n);
    logic [7:0]  rx;
    logic [31:0] d;
    d = w;
    frame_begin();
    send_hdr(8'h02, a);
    for (int i = 0; i < n; i++) begin
      xfer(d[31:24], rx);
      model_mem[8'(int'(a[7:0]) + i)] = d[31:24];
      d = d << 8;
    end
    frame_end();
  endtask

  task automatic spi_read(input logic [23:0] a, input int n, input string tag,
                          output logic [31:0] w);
    logic [7:0] rx;
    frame_begin();
    send_hdr(8'h03, a);
    w = 32'd0;
    for (int i = 0; i < n; i++) begin
      xfer(8'($urandom), rx);
      check(tag, {24'd0, rx}, {24'd0, model_mem[8'(int'(a[7:0]) + i)]});
      w = {w[23:0], rx};
    end
    frame_end();
  endtask

  task automatic backdoor(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    load_addr = a;
    load_data = d;
    load_en   = 1'b1;
    @(negedge clk);
    load_en   = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] w;
    logic [7:0]  rx;
    logic        r;
    logic [7:0]  old;

    repeat (4) @(negedge clk);
    check("reset_miso", {31'd0, miso}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // Give every byte a known value so any later read has a defined expectation.
    for (int a = 0; a < 256; a++) begin
      model_mem[a] = 8'($urandom);
      backdoor(8'(a), model_mem[a]);
    end

    spi_write(24'h000010, 32'hDEADBEEF, 4);
    spi_read(24'h000010, 4, "rd_deadbeef_byte", w);
    check("rd_deadbeef_word", w, 32'hDEADBEEF);

    backdoor(8'hFF, 8'h5A);
    model_mem[8'hFF] = 8'h5A;
    spi_read(24'h0000FF, 2, "rd_wrap_byte", w);
    check("rd_wrap_first", {24'd0, w[15:8]}, 32'h5A);
    spi_write(24'h0000FF, 32'hC3A50000, 2);
    spi_read(24'h0000FF, 2, "wr_wrap_byte", w);
    check("wr_wrap_word", {16'd0, w[15:0]}, 32'hC3A5);

    // Unknown command: data that looks like a WRITE header must not reach memory,
    // and a backdoor strobe while selected must be ignored.
    frame_begin();
    xfer(8'h9F, rx);
    check("ign_cmd_miso", {24'd0, rx}, 32'd0);
    xfer(8'h02, rx);
    check("ign_miso", {24'd0, rx}, 32'd0);
    backdoor(8'h77, ~model_mem[8'h77]);
    xfer(8'h00, rx);
    check("ign_miso", {24'd0, rx}, 32'd0);
    xfer(8'h00, rx);
    check("ign_miso", {24'd0, rx}, 32'd0);
    xfer(8'h30, rx);
    check("ign_miso", {24'd0, rx}, 32'd0);
    frame_end();
    spi_read(24'h000077, 1, "load_while_busy", w);
    spi_read(24'h000030, 1, "ign_no_write", w);

    // Partial data byte is discarded.
    frame_begin();
    send_hdr(8'h02, 24'h000020);
    old = ~model_mem[8'h20];
    for (int i = 7; i >= 3; i--) spi_bit(old[i], r);
    frame_end();
    spi_read(24'h000020, 2, "partial_wr", w);

    // Frame aborted mid-address.
    frame_begin();
    xfer(8'h03, rx);
    xfer(8'h00, rx);
    for (int i = 0; i < 4; i++) spi_bit(1'b1, r);
    frame_end();
    spi_read(24'h000010, 4, "after_abort", w);

    // Reset pulse during a read; the rest of the old frame must be ignored.
    frame_begin();
    send_hdr(8'h03, 24'h000040);
    xfer(8'h00, rx);
    check("rd_before_reset", {24'd0, rx}, {24'd0, model_mem[8'h40]});
    for (int i = 0; i < 3; i++) spi_bit(1'b0, r);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid_miso", {31'd0, miso}, 32'd0);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) spi_bit(1'b0, r);
    xfer(8'h02, rx);
    check("post_rst_miso", {24'd0, rx}, 32'd0);
    xfer(8'h00, rx);
    check("post_rst_miso", {24'd0, rx}, 32'd0);
    xfer(8'h00, rx);
    check("post_rst_miso", {24'd0, rx}, 32'd0);
    xfer(8'h40, rx);
    check("post_rst_miso", {24'd0, rx}, 32'd0);
    xfer(~model_mem[8'h40], rx);
    check("post_rst_miso", {24'd0, rx}, 32'd0);
    frame_end();
    spi_read(24'h000040, 3, "after_reset", w);

    for (int t = 0; t < 20; t++) begin
      if ($urandom_range(0, 1) == 0)
        spi_write(24'($urandom), $urandom, int'($urandom_range(1, 4)));
      else
        spi_read(24'($urandom), int'($urandom_range(1, 4)), "rand_rd", w);
    end

    // Whole-array sweep catches any stray write from the ignored/aborted frames.
    spi_read({16'($urandom), 8'h00}, 256, "final_dump", w);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
